// File: rtl/alu_ctrl_fsm.sv
// rtl/alu_ctrl_fsm.sv - instruction fetch/decode control FSM driving the ALU select and datapath enables
// Optional macro: ALU_CTRL_ILLEGAL_TRAP_EN (illegal opcodes trap to Halt and set sticky Illegal)
module alu_ctrl_fsm #(
   parameter int DAW = 8,
   parameter int RAW = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [15:0]      IR_in,
   output logic             PC_clr,
   output logic             PC_up,
   output logic [DAW-1:0]   D_addr,
   output logic             D_wr,
   output logic             RF_s,
   output logic [RAW-1:0]   RF_W_addr,
   output logic             RF_W_en,
   output logic [RAW-1:0]   RF_Ra_addr,
   output logic [RAW-1:0]   RF_Rb_addr,
   output logic [2:0]       ALU_s0,
   output logic             Halted,
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   output logic [3:0]       OutState,
   output logic             Illegal
`else
   output logic [3:0]       OutState
`endif
);

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOADA  = 4'd4,
      S_LOADB  = 4'd5,
      S_STORE  = 4'd6,
      S_ALUOP  = 4'd7,
      S_HALT   = 4'd8
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
   localparam logic [3:0] OP_LOAD  = 4'd2;
   localparam logic [3:0] OP_ADD   = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_HALT  = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_OR    = 4'd7;
   localparam logic [3:0] OP_AND   = 4'd8;
   localparam logic [3:0] OP_INC   = 4'd9;
   localparam logic [3:0] OP_MOV   = 4'd10;

   state_t           state_q, state_d;
   logic [15:0]      ir_q, ir_d;
   logic             pc_clr_q, pc_clr_d;
   logic             pc_up_q, pc_up_d;
   logic             d_wr_q, d_wr_d;
   logic             rf_s_q, rf_s_d;
   logic             rf_w_en_q, rf_w_en_d;
   logic [RAW-1:0]   rf_ra_addr_q, rf_ra_addr_d;
   logic [2:0]       alu_s0_q, alu_s0_d;
   logic             halted_q, halted_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   logic             illegal_q, illegal_d;
`endif

   // Opcode to ALU function code; anything that is not an ALU operation selects 0.
   function automatic logic [2:0] alu_sel(input logic [3:0] op);
      case (op)
         OP_ADD:  alu_sel = 3'd1;
         OP_SUB:  alu_sel = 3'd2;
         OP_MOV:  alu_sel = 3'd3;
         OP_XOR:  alu_sel = 3'd4;
         OP_OR:   alu_sel = 3'd5;
         OP_AND:  alu_sel = 3'd6;
         OP_INC:  alu_sel = 3'd7;
         default: alu_sel = 3'd0;
      endcase
   endfunction

   // Next state, IR capture, and output values for the state being entered,
   // so every output is a flop decoded from the upcoming state and IR.
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;

      case (state_q)
         S_INIT:   state_d = S_FETCH;
         S_FETCH: begin
            ir_d    = IR_in;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            case (ir_q[15:12])
               OP_NOOP:  state_d = S_NOOP;
               OP_STORE: state_d = S_STORE;
               OP_LOAD:  state_d = S_LOADA;
               OP_HALT:  state_d = S_HALT;
               OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND, OP_INC, OP_MOV:
                         state_d = S_ALUOP;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
               default:  state_d = S_HALT;
`else
               default:  state_d = S_NOOP;
`endif
            endcase
         end
         S_NOOP:   state_d = S_FETCH;
         S_LOADA:  state_d = S_LOADB;
         S_LOADB:  state_d = S_FETCH;
         S_STORE:  state_d = S_FETCH;
         S_ALUOP:  state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_INIT;
      endcase

      pc_clr_d     = (state_d == S_INIT);
      pc_up_d      = (state_d == S_FETCH);
      d_wr_d       = (state_d == S_STORE);
      rf_s_d       = (state_d == S_LOADB);
      rf_w_en_d    = (state_d == S_LOADB) || (state_d == S_ALUOP);
      alu_s0_d     = (state_d == S_ALUOP) ? alu_sel(ir_d[15:12]) : 3'd0;
      rf_ra_addr_d = (state_d == S_STORE) ? ir_d[3:0] : ir_d[11:8];
      halted_d     = (state_d == S_HALT);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
      // Opcodes 11-15 are the only way Decode reaches Halt with opcode != HALT.
      illegal_d    = illegal_q ||
                     ((state_q == S_DECODE) && (state_d == S_HALT) && (ir_q[15:12] > OP_MOV));
`endif
   end

   // State, IR and registered outputs; reset abandons any in-flight write at once.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_INIT;
         ir_q         <= 16'd0;
         pc_clr_q     <= 1'b1;
         pc_up_q      <= 1'b0;
         d_wr_q       <= 1'b0;
         rf_s_q       <= 1'b0;
         rf_w_en_q    <= 1'b0;
         rf_ra_addr_q <= '0;
         alu_s0_q     <= 3'd0;
         halted_q     <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
         illegal_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         ir_q         <= ir_d;
         pc_clr_q     <= pc_clr_d;
         pc_up_q      <= pc_up_d;
         d_wr_q       <= d_wr_d;
         rf_s_q       <= rf_s_d;
         rf_w_en_q    <= rf_w_en_d;
         rf_ra_addr_q <= rf_ra_addr_d;
         alu_s0_q     <= alu_s0_d;
         halted_q     <= halted_d;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
         illegal_q    <= illegal_d;
`endif
      end
   end

   assign PC_clr     = pc_clr_q;
   assign PC_up      = pc_up_q;
   assign D_addr     = ir_q[11:4];
   assign D_wr       = d_wr_q;
   assign RF_s       = rf_s_q;
   assign RF_W_addr  = ir_q[3:0];
   assign RF_W_en    = rf_w_en_q;
   assign RF_Ra_addr = rf_ra_addr_q;
   assign RF_Rb_addr = ir_q[7:4];
   assign ALU_s0     = alu_s0_q;
   assign Halted     = halted_q;
   assign OutState   = state_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
   assign Illegal    = illegal_q;
`endif

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Control unit that drives the ALU's 3-bit function select. It owns the opposite side of that select interface.
- Fetches 16-bit instructions, decodes the opcode and sequences the datapath: PC, instruction memory, data memory and register file.
- Produces the ALU select code, register-file and data-memory addresses, and write enables for each instruction.
- Moore FSM plus instruction register (IR). Sits between instruction memory and the datapath.

Parameters:
- DAW, 8, data-memory address width; taken from IR[11:4], so DAW must be 8.
- RAW, 4, register-file address width.

Ports:
- Clk  in  1  system clock; rising edge.
- Reset  in  1  asynchronous, active-high; forces state Init and clears IR.
- IR_in  in  16  instruction-memory read data for the current PC.
- PC_clr  out  1  clears the program counter.
- PC_up  out  1  increments the program counter.
- D_addr  out  DAW  data-memory address = IR[11:4].
- D_wr  out  1  data-memory write enable.
- RF_s  out  1  register-file write-data mux; 1 = memory data, 0 = ALU result Q.
- RF_W_addr  out  RAW  register-file write address = IR[3:0].
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  RAW  read port A address.
- RF_Rb_addr  out  RAW  read port B address = IR[7:4].
- ALU_s0  out  3  ALU function select.
- Halted  out  1  high while in state Halt.
- OutState  out  4  state encoding, for debug display.

Behaviour:
- Instruction fields: opcode IR[15:12]; Ra IR[11:8]; Rb IR[7:4]; Rc IR[3:0]. LOAD and STORE use addr IR[11:4] and register IR[3:0].
- Opcodes:
  - 0 NOOP
  - 1 STORE: D[addr] <= R[IR[3:0]]
  - 2 LOAD: R[IR[3:0]] <= D[addr]
  - 3 ADD, 4 SUB, 6 XOR, 7 OR, 8 AND: Rc <= Ra op Rb
  - 5 HALT
  - 9 INC: Rc <= Ra+1
  - 10 MOV: Rc <= Ra
  - 11-15 illegal
- ALU_s0 mapping: ADD=1, SUB=2, MOV=3, XOR=4, OR=5, AND=6, INC=7, all else 0.
- Address outputs:
  - RF_Ra_addr = IR[3:0] in Store, otherwise IR[11:8].
  - D_addr, RF_W_addr and RF_Rb_addr follow IR combinationally in every state.
- States and OutState codes: Init=0, Fetch=1, Decode=2, NoOp=3, LoadA=4, LoadB=5, Store=6, AluOp=7, Halt=8.
- Transitions and outputs:
  - Init: PC_clr=1; next Fetch.
  - Fetch: IR <= IR_in, PC_up=1; next Decode.
  - Decode: all enables 0. Next state by opcode: 0 or illegal -> NoOp; 1 -> Store; 2 -> LoadA; 5 -> Halt; ALU opcodes -> AluOp.
  - NoOp: all enables 0; next Fetch.
  - LoadA: covers the synchronous memory read; enables 0; next LoadB.
  - LoadB: RF_s=1, RF_W_en=1; next Fetch.
  - Store: D_wr=1; next Fetch.
  - AluOp: ALU_s0 per mapping, RF_s=0, RF_W_en=1; next Fetch.
  - Halt: Halted=1, all enables 0; stays until Reset.
- ALU_s0 is 0 in every state other than AluOp.
- Cycles per instruction: ALU/STORE/NOOP = 3, LOAD = 4 (counting Fetch).
- Reset values: state Init, IR=0, so all addresses are 0. Outputs are PC_clr=1, Halted=0, OutState=0 and every other output 0.
- Reset mid-instruction: an in-flight write is abandoned; no D_wr or RF_W_en pulse after Reset asserts.
- PC_clr and PC_up are never high together. D_wr and RF_W_en are never high together.
- All outputs are decoded from registered state and IR only; no combinational path from IR_in to outputs.

Optional Feature:
- Macro ALU_CTRL_ILLEGAL_TRAP_EN.
- Defined: opcodes 11-15 go Decode -> Halt and set a sticky output Illegal (1 bit, cleared only by Reset). Illegal rises the cycle Halt is entered.
- Not defined: illegal opcodes execute as NOOP; the Illegal port does not exist.

Test Plan:
- Reset released, IR_in=16'h3123 (ADD R3=R1+R2):
  - Cycle sequence Init -> Fetch -> Decode -> AluOp.
  - PC_clr=1 only in Init; PC_up=1 only in Fetch.
  - In AluOp: ALU_s0=1, RF_W_en=1, RF_s=0, RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=3.
- IR_in=16'h2A57 (LOAD R7 <= D[0xA5]):
  - LoadA then LoadB; D_addr=8'hA5.
  - RF_W_en=1 and RF_s=1 in LoadB only; 4 cycles from Fetch to next Fetch.
- IR_in=16'h1334 (STORE D[0x33] <= R4):
  - Store state: D_wr=1 for exactly one cycle, D_addr=8'h33, RF_Ra_addr=4, RF_W_en=0.
- Sweep opcodes 3,4,10,6,7,8,9 -> ALU_s0 = 1,2,3,4,5,6,7 in AluOp; opcode 0 -> ALU_s0 stays 0, no write.
- IR_in=16'h5000 (HALT):
  - Halted=1, OutState=8, held for 20 cycles with no PC_up.
  - Reset pulse in the middle of AluOp: outputs go to reset values immediately, with no RF_W_en.
- IR_in=16'hC000: without the macro -> behaves as NOOP and returns to Fetch. With ALU_CTRL_ILLEGAL_TRAP_EN -> Halt, Illegal=1.
